// File: rtl/crypto_instr_pkg.sv
// crypto_instr_pkg: shared constants and types for the crypto instruction unit
package crypto_instr_pkg;
  localparam int SHA512_ROUNDS    = 80;
  localparam int SHA512_BLK_WORDS = 16;
  typedef enum logic [1:0] {LOAD, EMIT, DONE} sha512_sched_state_t;
endpackage

// File: rtl/crypto_sha512_msg_sched_if.sv
// crypto_sha512_msg_sched_if: message-in / schedule-out handshake bundle
interface crypto_sha512_msg_sched_if;
  logic        msg_valid_i;
  logic        msg_ready_o;
  logic [63:0] msg_word_i;
  logic        w_valid_o;
  logic        w_ready_i;
  logic [63:0] w_word_o;
  logic [6:0]  w_idx_o;
  modport slave (input msg_valid_i, msg_word_i, w_ready_i, output msg_ready_o, w_valid_o, w_word_o, w_idx_o);
  modport master (output msg_valid_i, msg_word_i, w_ready_i, input msg_ready_o, w_valid_o, w_word_o, w_idx_o);
endinterface

// File: rtl/crypto_sha512_sigma.sv
// crypto_sha512_sigma: SHA-512 small sigma functions, sig0 on x0_i and sig1 on x1_i
module crypto_sha512_sigma (
  input  logic [63:0] x0_i,
  input  logic [63:0] x1_i,
  output logic [63:0] sig0_o,
  output logic [63:0] sig1_o
);
  assign sig0_o = {x0_i[0], x0_i[63:1]} ^ {x0_i[7:0], x0_i[63:8]} ^ (x0_i >> 7);
  assign sig1_o = {x1_i[18:0], x1_i[63:19]} ^ {x1_i[60:0], x1_i[63:61]} ^ (x1_i >> 6);
endmodule

// File: rtl/crypto_sha512_msg_sched.sv
// crypto_sha512_msg_sched: expands a 16-word block into the 80 SHA-512 schedule words
module crypto_sha512_msg_sched
  import crypto_instr_pkg::*;
#(
  parameter int NUM_ROUNDS = SHA512_ROUNDS,
  parameter int BLK_WORDS  = SHA512_BLK_WORDS
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             flush_i,
  crypto_sha512_msg_sched_if.slave         bus,
  output logic                             busy_o,
  output logic                             done_o
);
  sha512_sched_state_t state_q, state_d;
  logic [3:0]  lcnt_q, lcnt_d;
  logic [6:0]  t_q, t_d;
  logic [63:0] wbuf_q [BLK_WORDS];
  logic        msg_hs, w_hs, last_load, last_round, early;
  logic [3:0]  ti;
  logic [63:0] sig0, sig1, w_calc, w_cur;

  assign ti         = t_q[3:0];
  assign msg_hs     = bus.msg_valid_i & bus.msg_ready_o;
  assign w_hs       = bus.w_valid_o & bus.w_ready_i;
  assign last_load  = msg_hs && lcnt_q == 4'(BLK_WORDS - 1);
  assign last_round = w_hs && t_q == 7'(NUM_ROUNDS - 1);
  assign early      = t_q < 7'(BLK_WORDS);

  // the circular buffer holds W[t-16..t-1], so slot t&15 is W[t-16] until overwritten
  crypto_sha512_sigma u_sigma (
    .x0_i   (wbuf_q[ti + 4'd1]),
    .x1_i   (wbuf_q[ti + 4'd14]),
    .sig0_o (sig0),
    .sig1_o (sig1)
  );

  assign w_calc = sig1 + wbuf_q[ti + 4'd9] + sig0 + wbuf_q[ti];
  assign w_cur  = early ? wbuf_q[ti] : w_calc;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= LOAD;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = flush_i             ? LOAD :
              state_q == LOAD     ? (last_load ? EMIT : LOAD) :
              state_q == EMIT     ? (last_round ? DONE : EMIT) :
                                    LOAD;
  end

  always_comb begin
    bus.msg_ready_o = state_q == LOAD;
    bus.w_valid_o   = state_q == EMIT;
    bus.w_word_o    = state_q == EMIT ? w_cur : '0;
    bus.w_idx_o     = state_q == EMIT ? t_q : '0;
    busy_o          = !(state_q == LOAD && lcnt_q == 4'd0);
    done_o          = state_q == DONE;
  end

  always_comb begin
    lcnt_d = flush_i ? 4'd0 : msg_hs ? lcnt_q + 4'd1 : lcnt_q;
    t_d    = flush_i ? 7'd0 : w_hs ? (last_round ? 7'd0 : t_q + 7'd1) : t_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lcnt_q <= '0;
      t_q    <= '0;
    end else begin
      lcnt_q <= lcnt_d;
      t_q    <= t_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && !flush_i) begin
      if (msg_hs)                wbuf_q[lcnt_q] <= bus.msg_word_i;
      else if (w_hs && !early)   wbuf_q[ti] <= w_calc;
    end
  end
endmodule
